// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder with a fixed, parameterised response latency and a
// streaming dump port that walks through every memory word.
//
// Parameters
//   N        data word width in bits
//   DEPTH    number of memory words (word index = DM_addr[8:3])
//   LATENCY  clock edges from request acceptance to the DM_ready cycle (1..15)
//
// Ports
//   clk             single clock, all state changes on its rising edge
//   reset           synchronous, active-low reset
//   DM_addr         byte address; [8:3] selects the word, [2:0] checked for alignment
//   DM_writeData    store data
//   DM_writeEnable  store request level
//   DM_readEnable   load request level
//   DM_readData     load response data, held until the next read response
//   DM_ready        one-cycle pulse completing the current request
//   DM_misaligned   valid with DM_ready; accepted address had [2:0] != 0
//   dump            dump trigger, acts on its rising edge
//   dump_valid      high for each streamed dump word
//   dump_idx        word index of the streamed word
//   dump_data       contents of the streamed word
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int N       = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         DM_ready,
    output logic         DM_misaligned,
    input  logic         dump,
    output logic         dump_valid,
    output logic [5:0]   dump_idx,
    output logic [N-1:0] dump_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DUMP = 2'd3;

    localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    logic [1:0]   state;
    logic         dump_pending;
    logic         dump_prev;
    logic [3:0]   counter;
    logic         req_read;
    logic         req_misaligned;
    logic [N-1:0] read_word;
    logic [N-1:0] mem [DEPTH];

    logic [5:0]   word_idx;
    logic         addr_misaligned;
    logic         dump_rise;
    logic [5:0]   next_dump_idx;
    logic         unused_addr_bits;

    assign word_idx        = DM_addr[8:3];
    assign addr_misaligned = (DM_addr[2:0] != 3'd0);
    assign dump_rise       = dump & ~dump_prev;
    assign next_dump_idx   = dump_idx + 6'd1;

    // Address bits above the word index are deliberately ignored, so the
    // address space wraps every 512 bytes.
    assign unused_addr_bits = ^DM_addr[N-1:9];

    // Main sequencer. DM_ready/DM_misaligned are registered and default low,
    // so they are high only in the single cycle spent in RESP. The read word
    // is captured at acceptance, which keeps an in-flight read immune to any
    // later store to the same word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            dump_pending   <= 1'b0;
            dump_prev      <= 1'b0;
            counter        <= 4'd0;
            req_read       <= 1'b0;
            req_misaligned <= 1'b0;
            read_word      <= '0;
            DM_readData    <= '0;
            DM_ready       <= 1'b0;
            DM_misaligned  <= 1'b0;
            dump_valid     <= 1'b0;
            dump_idx       <= 6'd0;
            dump_data      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            dump_prev     <= dump;
            DM_ready      <= 1'b0;
            DM_misaligned <= 1'b0;

            // A dump edge is only remembered once; the pending flag is cleared
            // solely when it is already set, so set and clear never collide.
            if (dump_rise && !dump_pending && (state != DUMP)) begin
                dump_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (dump_pending) begin
                        // Dump wins over a simultaneous request, which keeps
                        // waiting with its enables held.
                        state        <= DUMP;
                        dump_pending <= 1'b0;
                        dump_idx     <= 6'd0;
                        dump_data    <= mem[0];
                        dump_valid   <= 1'b1;
                    end else if (DM_writeEnable || DM_readEnable) begin
                        // Both enables high is treated as a write.
                        req_read       <= !DM_writeEnable;
                        req_misaligned <= addr_misaligned;
                        read_word      <= mem[word_idx];
                        counter        <= LAT_M1;
                        if (DM_writeEnable) begin
                            mem[word_idx] <= DM_writeData;
                        end
                        if (LATENCY == 1) begin
                            state         <= RESP;
                            DM_ready      <= 1'b1;
                            DM_misaligned <= addr_misaligned;
                            if (!DM_writeEnable) begin
                                DM_readData <= mem[word_idx];
                            end
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    counter <= counter - 4'd1;
                    // The edge that takes the counter to zero is the one
                    // that enters RESP.
                    if (counter == 4'd1) begin
                        state         <= RESP;
                        DM_ready      <= 1'b1;
                        DM_misaligned <= req_misaligned;
                        if (req_read) begin
                            DM_readData <= read_word;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                DUMP: begin
                    // The index stops at the last word rather than wrapping.
                    if (dump_idx == LAST_IDX) begin
                        state      <= IDLE;
                        dump_valid <= 1'b0;
                    end else begin
                        dump_idx  <= next_dump_idx;
                        dump_data <= mem[next_dump_idx];
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the number of words; word index = DM_addr[8:3].
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request acceptance to response; legal range 1..15.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, reset; synchronous and active-low.
REQ-006 Port DM_addr, input, N, the byte address; bits [8:3] select the word and bits [2:0] are checked for alignment.
REQ-007 Port DM_writeData, input, N, the store data.
REQ-008 Port DM_writeEnable, input, 1, the store request level.
REQ-009 Port DM_readEnable, input, 1, the load request level.
REQ-010 Port DM_readData, output, N, the load response data.
REQ-011 Port DM_ready, output, 1, a one-cycle response pulse completing the current request.
REQ-012 Port DM_misaligned, output, 1, valid with DM_ready; high when the accepted DM_addr[2:0] != 0.
REQ-013 Port dump, input, 1, the dump trigger; acts on its rising edge.
REQ-014 Port dump_valid, output, 1, high for each streamed dump word.
REQ-015 Port dump_idx, output, 6, the word index of the streamed word.
REQ-016 Port dump_data, output, N, the streamed word contents.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, BUSY, RESP and DUMP.
REQ-018 In IDLE with dump_pending=0, DM_writeEnable=1 or DM_readEnable=1 SHALL accept a request at that edge: latch address, kind and data; load counter = LATENCY-1; go to BUSY, or to RESP if LATENCY=1.
REQ-019 Write and read both high SHALL be treated as a write; DM_readData SHALL stay unchanged.
REQ-020 A write SHALL update mem[idx] at the acceptance edge.
REQ-021 A read SHALL capture mem[idx] at the acceptance edge, so a later write cannot alter an in-flight read.
REQ-022 BUSY SHALL decrement the counter each edge and enter RESP when the counter reaches 0.
REQ-023 In RESP, DM_ready SHALL be 1 for exactly one cycle, giving DM_ready high in the cycle starting LATENCY edges after acceptance.
REQ-024 For a read, DM_readData SHALL take the captured word at the edge entering RESP and hold it until the next read response or reset.
REQ-025 RESP SHALL always return to IDLE; enables still high in IDLE SHALL start a new request, as the initiator drops its enables on DM_ready.
REQ-026 Enables SHALL be ignored outside IDLE, and enable changes during BUSY SHALL not affect the in-flight request.
REQ-027 DM_addr bits above [8:3] SHALL be ignored, so addresses wrap modulo 512 bytes; misaligned accesses SHALL proceed using [8:3] with DM_misaligned=1.
REQ-028 A dump rising edge in any state SHALL set dump_pending; edges while dump_pending=1 or in DUMP SHALL be ignored.
REQ-029 In IDLE with dump_pending=1, the FSM SHALL enter DUMP, clear dump_pending and reset dump_idx to 0; dump SHALL take priority over a simultaneous request, which waits.
REQ-030 In DUMP, each cycle SHALL have dump_valid=1, dump_data=mem[dump_idx] and dump_idx incrementing, across 64 consecutive cycles for indices 0..63.
REQ-031 After index 63 the FSM SHALL return to IDLE with dump_valid=0 and the counter not wrapping; DM_ready SHALL stay 0 throughout DUMP.
REQ-032 DM_ready, DM_misaligned and dump_valid SHALL never be asserted in the same cycle as each other's source state, and SHALL be 0 in IDLE and BUSY.

Reset
REQ-033 With reset=0 at a rising edge, the block SHALL enter IDLE and clear to 0 all of: dump_pending, counter, DM_ready, DM_misaligned, DM_readData, dump_valid, dump_idx, dump_data and all DEPTH memory words.
REQ-034 Reset mid-BUSY, mid-RESP or mid-DUMP SHALL abort the operation with no DM_ready pulse; a write accepted before reset SHALL be lost through the memory clear.
REQ-035 The first request SHALL be accepted no earlier than the first edge with reset=1.

Verification
REQ-036 Write 0xDEAD_BEEF to addr 0x10, then read 0x10 with LATENCY=2 -> DM_ready high exactly 2 edges after each acceptance; DM_readData=0xDEAD_BEEF; DM_misaligned=0.
REQ-037 Read 0x13 after writing 0x11 to 0x10 -> DM_readData=0x11 and DM_misaligned=1 in the ready cycle; an address of 0x210 aliases word 2.
REQ-038 Both enables high, addr 0x08, data 0x5 -> mem[1]=5 and DM_readData unchanged from the prior value.
REQ-039 Dump pulse during a BUSY read -> the read completes with DM_ready, then 64 dump_valid cycles with dump_idx 0..63 and data matching prior writes; a request held during the dump is accepted after index 63.
REQ-040 reset=0 during BUSY -> no DM_ready; a following read of that address returns 0.
REQ-041 LATENCY=1 back-to-back reads held high -> DM_ready pulses every 2 cycles.
